// File: rtl/shoplift_monitor.sv
// -----------------------------------------------------------------------------
// shoplift_monitor
//
// Watches a checkout scanner stream. Each accepted item is classified by its
// code as "discounted" and/or "expensive". Discounted items raise a one-cycle
// disc_led pulse and bump disc_count. A returned expensive item without the
// secret mark is a stolen event: it bumps stolen_count and raises the alarm.
// While the alarm is up the scanner is blocked until the operator clears it;
// after the clear the scanner stays blocked for HOLD_CYCLES more cycles.
//
// Ports
//   clk           in   1      single clock, all state changes on rising edge
//   reset_n       in   1      asynchronous active-low reset
//   item_valid    in   1      scanned item present this cycle
//   item_upc      in   UPC_W  item code
//   item_mark     in   1      secret mark present on item
//   item_return   in   1      1 = return, 0 = purchase
//   item_ready    out  1      block accepts an item this cycle (combinational)
//   alarm_clr     in   1      operator acknowledge of the stolen alarm
//   count_clr     in   1      synchronous clear of both counters
//   disc_led      out  1      one-cycle pulse per accepted discounted item
//   stolen_led    out  1      high while the alarm is active
//   disc_count    out  CNT_W  accepted discounted items since last clear
//   stolen_count  out  CNT_W  stolen events since last clear
//   state_o       out  2      FSM state (IDLE=0, ALARM=1, HOLD=2)
// -----------------------------------------------------------------------------
module shoplift_monitor #(
    parameter int                       UPC_W       = 3,
    parameter logic [(1<<UPC_W)-1:0]    DISC_MASK   = 8'b1110_1100,
    parameter logic [(1<<UPC_W)-1:0]    EXP_MASK    = 8'b0011_0001,
    parameter int                       CNT_W       = 8,
    parameter int                       HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              item_valid,
    input  logic [UPC_W-1:0]  item_upc,
    input  logic              item_mark,
    input  logic              item_return,
    output logic              item_ready,
    input  logic              alarm_clr,
    input  logic              count_clr,
    output logic              disc_led,
    output logic              stolen_led,
    output logic [CNT_W-1:0]  disc_count,
    output logic [CNT_W-1:0]  stolen_count,
    output logic [1:0]        state_o
);

    localparam int               CODES     = 1 << UPC_W;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [7:0]       HOLD_LOAD = 8'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALARM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Item classification: one-hot decode of the code, then select the mask
    // bits. Doing it as a decode keeps the mask lookup a plain AND/OR tree.
    // -------------------------------------------------------------------------
    logic [CODES-1:0] code_hit;

    for (genvar gi = 0; gi < CODES; gi++) begin : g_decode
        assign code_hit[gi] = (item_upc == UPC_W'(gi));
    end

    logic is_disc;
    logic is_exp;

    assign is_disc = |(code_hit & DISC_MASK);
    assign is_exp  = |(code_hit & EXP_MASK);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_reg;
    state_t           state_next;
    logic [7:0]       hold_reg;
    logic [7:0]       hold_next;
    logic             disc_led_reg;
    logic [CNT_W-1:0] disc_count_reg;
    logic [CNT_W-1:0] disc_count_next;
    logic [CNT_W-1:0] stolen_count_reg;
    logic [CNT_W-1:0] stolen_count_next;

    // Handshake and event qualification.
    logic accept;
    logic disc_hit;
    logic stolen_hit;

    // item_ready also looks at reset_n so the scanner is blocked the very
    // moment reset is asserted, without waiting for a clock edge.
    assign item_ready = (state_reg == ST_IDLE) && reset_n;
    assign accept     = item_valid && item_ready;
    assign disc_hit   = accept && is_disc;
    assign stolen_hit = accept && item_return && is_exp && !item_mark;

    // -------------------------------------------------------------------------
    // FSM process 1: state register (also holds the lockout counter)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            hold_reg  <= 8'd0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        case (state_reg)
            ST_IDLE: begin
                // alarm_clr is meaningless here; a stolen event always wins.
                if (stolen_hit) begin
                    state_next = ST_ALARM;
                end
            end
            ST_ALARM: begin
                if (alarm_clr) begin
                    state_next = ST_HOLD;
                    hold_next  = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                // The counter is loaded with HOLD_CYCLES on entry, so leaving
                // on the edge where it reaches zero gives exactly HOLD_CYCLES
                // cycles in HOLD. A zero count (only possible from a corrupted
                // register) leaves at once instead of wrapping to 255.
                if (hold_reg <= 8'd1) begin
                    state_next = ST_IDLE;
                    hold_next  = 8'd0;
                end else begin
                    hold_next  = hold_reg - 8'd1;
                end
            end
            default: begin
                // Unused encoding 3: recover to IDLE.
                state_next = ST_IDLE;
                hold_next  = 8'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM process 3: state-derived outputs
    // -------------------------------------------------------------------------
    always_comb begin
        stolen_led = (state_reg == ST_ALARM);
        state_o    = state_reg;
    end

    // -------------------------------------------------------------------------
    // Event counters: saturating, with count_clr taking priority over any
    // increment in the same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        disc_count_next   = disc_count_reg;
        stolen_count_next = stolen_count_reg;
        if (count_clr) begin
            disc_count_next   = '0;
            stolen_count_next = '0;
        end else begin
            if (disc_hit && (disc_count_reg != CNT_MAX)) begin
                disc_count_next = disc_count_reg + CNT_ONE;
            end
            if (stolen_hit && (stolen_count_reg != CNT_MAX)) begin
                stolen_count_next = stolen_count_reg + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disc_count_reg   <= '0;
            stolen_count_reg <= '0;
            disc_led_reg     <= 1'b0;
        end else begin
            disc_count_reg   <= disc_count_next;
            stolen_count_reg <= stolen_count_next;
            // Registered straight from the accept, so back-to-back discounted
            // items produce back-to-back pulses.
            disc_led_reg     <= disc_hit;
        end
    end

    assign disc_led     = disc_led_reg;
    assign disc_count   = disc_count_reg;
    assign stolen_count = stolen_count_reg;

endmodule

// File: doc/shoplift_monitor.md
SHOPLIFT_MONITOR -- requirements
Module: shoplift_monitor

Interface
REQ-001 Parameter UPC_W, default 3: item code width; code space is 2**UPC_W entries.
REQ-002 Parameter DISC_MASK, width 2**UPC_W, default 8'b1110_1100: bit k=1 marks code k as discounted.
REQ-003 Parameter EXP_MASK, width 2**UPC_W, default 8'b0011_0001: bit k=1 marks code k as expensive.
REQ-004 Parameter CNT_W, default 8: width of each event counter.
REQ-005 Parameter HOLD_CYCLES, default 4, range 1..255: lockout length after alarm clear.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 item_valid  in  1  scanned item present this cycle.
REQ-009 item_upc  in  UPC_W  item code.
REQ-010 item_mark  in  1  secret mark present on item.
REQ-011 item_return  in  1  1 = item being returned, 0 = purchase.
REQ-012 item_ready  out  1  block accepts an item this cycle.
REQ-013 alarm_clr  in  1  operator acknowledge of stolen alarm.
REQ-014 count_clr  in  1  synchronous clear of both counters.
REQ-015 disc_led  out  1  registered one-cycle pulse per accepted discounted item.
REQ-016 stolen_led  out  1  high while state is ALARM.
REQ-017 disc_count  out  CNT_W  accepted discounted items since last clear.
REQ-018 stolen_count  out  CNT_W  stolen events since last clear.
REQ-019 state_o  out  2  current FSM state encoding (IDLE=0, ALARM=1, HOLD=2).

Function
REQ-020 Accept = item_valid & item_ready on a rising clk edge; no item is consumed otherwise.
REQ-021 item_ready is combinational: 1 only in IDLE with reset_n high; 0 in ALARM and HOLD.
REQ-022 Discounted = DISC_MASK[item_upc]; applies to purchases and returns alike.
REQ-023 Stolen event = accept & item_return & EXP_MASK[item_upc] & ~item_mark.
REQ-024 disc_led is 1 on the cycle after an accepted discounted item, else 0; latency exactly 1 cycle.
REQ-025 Back-to-back accepted discounted items yield disc_led high on consecutive cycles, one pulse per item.
REQ-026 disc_count increments by 1 per accepted discounted item; saturates at 2**CNT_W-1, no wrap.
REQ-027 stolen_count increments by 1 per stolen event; saturates at 2**CNT_W-1, no wrap.
REQ-028 count_clr sets both counters to 0 on the next edge; it overrides a same-cycle increment (result 0).
REQ-029 FSM IDLE -> ALARM on a stolen event; that item still counts (disc_count, disc_led apply).
REQ-030 ALARM holds indefinitely until alarm_clr=1, then -> HOLD with hold counter loaded to HOLD_CYCLES.
REQ-031 HOLD decrements its counter each cycle; -> IDLE on the edge where the counter reaches 0 (exactly HOLD_CYCLES cycles in HOLD).
REQ-032 alarm_clr in IDLE or HOLD has no effect; alarm_clr with a same-cycle accept in IDLE: the stolen event wins (-> ALARM).
REQ-033 item_valid in ALARM/HOLD is ignored: no counts, no disc_led, no state change.
REQ-034 Illegal state encoding 3 -> IDLE on next edge.

Reset
REQ-035 reset_n low asynchronously forces: state IDLE, disc_count 0, stolen_count 0, disc_led 0, hold counter 0, item_ready 0.
REQ-036 Reset asserted mid-ALARM or mid-HOLD aborts immediately to IDLE; first accept possible on the first edge with reset_n high.

Verification
REQ-037 Defaults, purchases of codes 0..7 with mark=0 back-to-back -> disc_led pulses for codes 2,3,5,6,7 only; disc_count=5; stolen_count=0; state stays IDLE.
REQ-038 Return code 4, mark=0 -> next cycle stolen_led=1, stolen_count=1, item_ready=0; return code 4 mark=1 from IDLE -> no alarm.
REQ-039 In ALARM present item_valid for 3 cycles, then alarm_clr -> counts unchanged; item_ready=0 exactly 4 cycles after clr edge, then 1.
REQ-040 CNT_W=2, 5 accepted discounted items -> disc_count 1,2,3,3,3; count_clr with a 6th item same cycle -> disc_count=0.
REQ-041 reset_n pulled low between edges during HOLD -> outputs zero immediately, state_o=0; after release a code-2 purchase -> disc_led next cycle.
REQ-042 UPC_W=4 with custom masks, sweep all 16 codes x mark x return -> disc/stolen behaviour matches masks per REQ-022/023.
